retire_trace_unit: RTL and testbench

- Synthesizable in-core producer of the per-cycle retire trace and statistics that the simulation bench records.
- Sits beside the pipeline's writeback/memory stages and packages REG/LOAD/STORE/HALT events into a buffered record stream with a valid/ready handshake.
- Keeps cycle, instruction and cache counters; drains and signals done after halt.

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_fifo.sv | 42 ++++
 rtl/retire_trace_unit.sv | 135 +++++++++++++
 tb/tb_retire_trace_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: retire trace record layout and event-type encodings
package trace_pkg;
  localparam logic [1:0] TR_REG   = 2'd0;
  localparam logic [1:0] TR_LOAD  = 2'd1;
  localparam logic [1:0] TR_STORE = 2'd2;
  localparam logic [1:0] TR_HALT  = 2'd3;
  localparam int REC_W       = 34;
  localparam int REC_TYPE_HI = 33;
  localparam int REC_TYPE_LO = 32;
  localparam int REC_A_HI    = 31;
  localparam int REC_A_LO    = 16;
  localparam int REC_B_HI    = 15;
  localparam int REC_B_LO    = 0;
  typedef logic [REC_W-1:0] rec_t;
  function automatic rec_t mk_rec(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b);
    return {t, a, b};
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular record buffer accepting up to three pushes and one pop per cycle
// Ports: clk/rst (async, active-high); i_push_cnt records i_rec0..i_rec2 written in order;
// i_pop advances the head; o_head is the oldest record; o_occ/o_free report fill level.
module trace_fifo import trace_pkg::*; #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    i_push_cnt,
  input  rec_t                          i_rec0,
  input  rec_t                          i_rec1,
  input  rec_t                          i_rec2,
  input  logic                          i_pop,
  output rec_t                          o_head,
  output logic [$clog2(FIFO_DEPTH):0]   o_occ,
  output logic [$clog2(FIFO_DEPTH):0]   o_free
);
  localparam int AW = $clog2(FIFO_DEPTH);
  rec_t r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [AW-1:0] w_wa1, w_wa2;
  assign w_wa1 = r_wr[AW-1:0] + AW'(1);
  assign w_wa2 = r_wr[AW-1:0] + AW'(2);
  // Extra pointer MSB separates full (occ == DEPTH) from empty (occ == 0).
  assign o_occ  = r_wr - r_rd;
  assign o_free = (AW+1)'(FIFO_DEPTH) - o_occ;
  assign o_head = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(i_push_cnt);
      r_rd <= r_rd + (AW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push_cnt > 2'd0) r_mem[r_wr[AW-1:0]] <= i_rec0;
    if (i_push_cnt > 2'd1) r_mem[w_wa1] <= i_rec1;
    if (i_push_cnt > 2'd2) r_mem[w_wa2] <= i_rec2;
  end
endmodule

// File: rtl/retire_trace_unit.sv
// retire_trace_unit: packages retire events into a buffered valid/ready record stream with statistics
// Ports: clk, rst (async, active-high); retire inputs regWrite/writeReg/writeData, memRead/memWrite/
// memAddr/memDataIn/memDataOut, halt, cache strobes; record stream ev_valid/ev_ready/ev_type/ev_a/ev_b;
// status trace_afull/overflow/done; statistics counters.
// Macro TRACE_CACHE_STATS_EN builds the four cache counters; otherwise they read 0.
module retire_trace_unit import trace_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regWrite,
  input  logic [2:0]       writeReg,
  input  logic [15:0]      writeData,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [15:0]      memAddr,
  input  logic [15:0]      memDataIn,
  input  logic [15:0]      memDataOut,
  input  logic             halt,
  input  logic             iCacheReq,
  input  logic             iCacheHit,
  input  logic             dCacheReq,
  input  logic             dCacheHit,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_type,
  output logic [15:0]      ev_a,
  output logic [15:0]      ev_b,
  output logic             trace_afull,
  output logic             overflow,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] ic_req_cnt,
  output logic [CNT_W-1:0] ic_hit_cnt,
  output logic [CNT_W-1:0] dc_req_cnt,
  output logic [CNT_W-1:0] dc_hit_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0] r_state;
  logic r_pend, r_ovf;
  logic [CNT_W-1:0] r_cyc, r_inst;
  rec_t w_head, w_r0, w_r1, w_reg_rec, w_mem_rec, w_halt_rec;
  logic [AW:0] w_occ, w_free;
  logic [AW+1:0] w_room;
  logic [1:0] w_n, w_push;
  logic w_valid, w_pop, w_run, w_mem, w_fit, w_live;
  assign w_valid    = |w_occ;
  assign w_pop      = w_valid & ev_ready;
  assign w_run      = r_state == S_RUN;
  assign w_live     = w_run & ~r_pend;
  assign w_mem      = memRead | memWrite;
  assign w_reg_rec  = mk_rec(TR_REG, {13'b0, writeReg}, writeData);
  assign w_mem_rec  = memRead ? mk_rec(TR_LOAD, memAddr, memDataOut) : mk_rec(TR_STORE, memAddr, memDataIn);
  assign w_halt_rec = mk_rec(TR_HALT, 16'h0, 16'h0);
  // While a halt is pending only the HALT record is retried; everything else is ignored.
  assign w_r0   = (regWrite & ~r_pend) ? w_reg_rec : (w_mem & ~r_pend) ? w_mem_rec : w_halt_rec;
  assign w_r1   = (regWrite & w_mem) ? w_mem_rec : w_halt_rec;
  assign w_n    = r_pend ? 2'd1 : {1'b0, regWrite} + {1'b0, w_mem} + {1'b0, halt};
  // A slot freed by this cycle's pop is reusable by this cycle's pushes.
  assign w_room = (AW+2)'(w_free) + (AW+2)'(w_pop);
  assign w_fit  = (AW+2)'(w_n) <= w_room;
  assign w_push = (w_run & w_fit) ? w_n : 2'd0;
  trace_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_cnt (w_push),
    .i_rec0     (w_r0),
    .i_rec1     (w_r1),
    .i_rec2     (w_halt_rec),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_occ      (w_occ),
    .o_free     (w_free)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cyc   <= '0;
      r_inst  <= '0;
    end else begin
      if (w_run) begin
        r_cyc  <= r_cyc + CNT_W'(1);
        r_pend <= (r_pend | halt) & ~w_fit;
        if (w_live & (halt | regWrite | memWrite)) r_inst <= r_inst + CNT_W'(1);
        if (w_fit & (r_pend | halt)) r_state <= S_DRAIN;
        // Overflow only when a non-halt record is lost; a deferred halt alone is not a drop.
        if (w_live & ~w_fit & (w_n != 2'd1 | ~halt)) r_ovf <= 1'b1;
      end
      if (r_state == S_DRAIN && w_pop && w_head[REC_TYPE_HI:REC_TYPE_LO] == TR_HALT) r_state <= S_DONE;
    end
  end
`ifdef TRACE_CACHE_STATS_EN
  logic [CNT_W-1:0] r_icr, r_ich, r_dcr, r_dch;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_icr <= '0;
      r_ich <= '0;
      r_dcr <= '0;
      r_dch <= '0;
    end else if (w_live) begin
      r_icr <= r_icr + CNT_W'(iCacheReq);
      r_ich <= r_ich + CNT_W'(iCacheHit);
      r_dcr <= r_dcr + CNT_W'(dCacheReq);
      r_dch <= r_dch + CNT_W'(dCacheHit);
    end
  end
  assign ic_req_cnt = r_icr;
  assign ic_hit_cnt = r_ich;
  assign dc_req_cnt = r_dcr;
  assign dc_hit_cnt = r_dch;
`else
  logic w_unused_cache;
  assign w_unused_cache = ^{iCacheReq, iCacheHit, dCacheReq, dCacheHit};
  assign ic_req_cnt = '0;
  assign ic_hit_cnt = '0;
  assign dc_req_cnt = '0;
  assign dc_hit_cnt = '0;
`endif
  assign ev_valid    = w_valid;
  assign ev_type     = w_valid ? w_head[REC_TYPE_HI:REC_TYPE_LO] : 2'd0;
  assign ev_a        = w_valid ? w_head[REC_A_HI:REC_A_LO] : 16'h0;
  assign ev_b        = w_valid ? w_head[REC_B_HI:REC_B_LO] : 16'h0;
  assign trace_afull = w_free < (AW+1)'(3);
  assign overflow    = r_ovf;
  assign done        = r_state == S_DONE;
  assign cycle_cnt   = r_cyc;
  assign inst_cnt    = r_inst;
endmodule

// File: tb/tb_retire_trace_unit.sv
// tb_retire_trace_unit: directed and randomized checks of retire_trace_unit against a queue-based model
module tb_retire_trace_unit;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic regWrite = 0, memRead = 0, memWrite = 0, halt = 0, ev_ready = 0;
  logic iCacheReq = 0, iCacheHit = 0, dCacheReq = 0, dCacheHit = 0;
  logic [2:0] writeReg = 0;
  logic [15:0] writeData = 0, memAddr = 0, memDataIn = 0, memDataOut = 0;
  logic ev_valid, trace_afull, overflow, done;
  logic [1:0] ev_type;
  logic [15:0] ev_a, ev_b;
  logic [31:0] cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt;
  int checks = 0, failures = 0;
  // model: record queue plus run/drain/done phase, pending halt, sticky overflow, counters
  logic [33:0] mq[$];
  int m_state;
  bit m_pend, m_ovf;
  logic [31:0] m_cyc, m_inst, m_icr, m_ich, m_dcr, m_dch;

  always #5 clk = ~clk;

  retire_trace_unit #(.FIFO_DEPTH(D), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .halt(halt), .iCacheReq(iCacheReq), .iCacheHit(iCacheHit),
    .dCacheReq(dCacheReq), .dCacheHit(dCacheHit), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_type(ev_type), .ev_a(ev_a), .ev_b(ev_b), .trace_afull(trace_afull), .overflow(overflow),
    .done(done), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .ic_req_cnt(ic_req_cnt),
    .ic_hit_cnt(ic_hit_cnt), .dc_req_cnt(dc_req_cnt), .dc_hit_cnt(dc_hit_cnt)
  );

  function automatic logic [33:0] m_head();
    return mq.size() > 0 ? mq[0] : 34'h0;
  endfunction

  function automatic logic [191:0] m_cnts();
    return {m_cyc, m_inst, m_icr, m_ich, m_dcr, m_dch};
  endfunction

  task automatic idle();
    regWrite = 0; memRead = 0; memWrite = 0; halt = 0;
    iCacheReq = 0; iCacheHit = 0; dCacheReq = 0; dCacheHit = 0;
  endtask

  task automatic model_reset();
    mq.delete(); m_state = 0; m_pend = 0; m_ovf = 0;
    m_cyc = 0; m_inst = 0; m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0;
  endtask

  task automatic do_reset();
    idle(); ev_ready = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    logic [33:0] recs[$];
    logic [33:0] h;
    bit pop = mq.size() > 0 && ev_ready;
    int room = D - mq.size() + (pop ? 1 : 0);
    int nxt = m_state;
    if (m_state == 0) begin
      m_cyc++;
      if (m_pend) begin
        if (room >= 1) begin recs.push_back({2'd3, 32'h0}); m_pend = 0; nxt = 1; end
      end else begin
        if (regWrite) recs.push_back({2'd0, 13'h0, writeReg, writeData});
        if (memRead) recs.push_back({2'd1, memAddr, memDataOut});
        else if (memWrite) recs.push_back({2'd2, memAddr, memDataIn});
        if (halt) recs.push_back({2'd3, 32'h0});
        if (halt || regWrite || memWrite) m_inst++;
`ifdef TRACE_CACHE_STATS_EN
        if (iCacheReq) m_icr++;
        if (iCacheHit) m_ich++;
        if (dCacheReq) m_dcr++;
        if (dCacheHit) m_dch++;
`endif
        if (recs.size() > room) begin
          if (recs.size() > 1 || !halt) m_ovf = 1;
          if (halt) m_pend = 1;
          recs.delete();
        end else if (halt) nxt = 1;
      end
    end
    if (pop) begin
      h = mq.pop_front();
      if (m_state == 1 && h[33:32] == 2'd3) nxt = 2;
    end
    foreach (recs[i]) mq.push_back(recs[i]);
    m_state = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ev_valid); end
    checks++; if ({ev_type, ev_a, ev_b} !== 34'h0) begin failures++; $display("FAIL reset_rec got=%h exp=0", {ev_type, ev_a, ev_b}); end
    checks++; if ({trace_afull, overflow, done} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {trace_afull, overflow, done}); end
    checks++; if ({cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt} !== 192'h0) begin failures++; $display("FAIL reset_cnts got=%h exp=0", {cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt}); end
  endtask

  task automatic test_single_reg();
    ev_ready = 1; regWrite = 1; writeReg = 3'd5; writeData = 16'h1234;
    step(); idle();
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ev_valid); end
    checks++; if ({ev_type, ev_a, ev_b} !== {2'd0, 16'h0005, 16'h1234}) begin failures++; $display("FAIL single_rec got=%h exp=%h", {ev_type, ev_a, ev_b}, {2'd0, 16'h0005, 16'h1234}); end
    checks++; if (inst_cnt !== 32'd1) begin failures++; $display("FAIL single_inst got=%0d exp=1", inst_cnt); end
    step();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL single_popped got=%b exp=0", ev_valid); end
  endtask

  task automatic test_reg_store();
    ev_ready = 0; regWrite = 1; writeReg = 3'd2; writeData = 16'h00AA;
    memWrite = 1; memAddr = 16'h0040; memDataIn = 16'hBEEF;
    step(); idle();
    checks++; if ({ev_valid, ev_type, ev_a, ev_b} !== {1'b1, 2'd0, 16'h0002, 16'h00AA}) begin failures++; $display("FAIL pair_first got=%h exp=%h", {ev_valid, ev_type, ev_a, ev_b}, {1'b1, 2'd0, 16'h0002, 16'h00AA}); end
    ev_ready = 1; step();
    checks++; if ({ev_valid, ev_type, ev_a, ev_b} !== {1'b1, 2'd2, 16'h0040, 16'hBEEF}) begin failures++; $display("FAIL pair_second got=%h exp=%h", {ev_valid, ev_type, ev_a, ev_b}, {1'b1, 2'd2, 16'h0040, 16'hBEEF}); end
    checks++; if (inst_cnt !== 32'd2) begin failures++; $display("FAIL pair_inst got=%0d exp=2", inst_cnt); end
    step();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL pair_empty got=%b exp=0", ev_valid); end
  endtask

  task automatic test_load();
    ev_ready = 1; memRead = 1; memAddr = 16'h0100; memDataOut = 16'h0007; memDataIn = 16'hDEAD;
    step(); idle();
    checks++; if ({ev_valid, ev_type, ev_a, ev_b} !== {1'b1, 2'd1, 16'h0100, 16'h0007}) begin failures++; $display("FAIL load_rec got=%h exp=%h", {ev_valid, ev_type, ev_a, ev_b}, {1'b1, 2'd1, 16'h0100, 16'h0007}); end
    checks++; if (inst_cnt !== 32'd2) begin failures++; $display("FAIL load_inst got=%0d exp=2", inst_cnt); end
    step();
  endtask

  task automatic test_overflow();
    int pops = 0;
    ev_ready = 0;
    for (int i = 0; i < 14; i++) begin
      regWrite = 1; writeReg = 3'(i); writeData = 16'(16'h0100 + i);
      step();
    end
    idle();
    checks++; if ({trace_afull, overflow} !== 2'b10) begin failures++; $display("FAIL ovf_afull got=%b exp=10", {trace_afull, overflow}); end
    regWrite = 1; memWrite = 1; halt = 1; memAddr = 16'h0200; memDataIn = 16'h5555;
    step(); idle();
    checks++; if ({overflow, trace_afull, done} !== 3'b110) begin failures++; $display("FAIL ovf_drop got=%b exp=110", {overflow, trace_afull, done}); end
    step();
    for (int i = 0; i < 40 && !done; i++) begin
      ev_ready = 1;
      if (ev_valid) begin
        pops++;
        checks++; if ({ev_type, ev_a, ev_b} !== m_head()) begin failures++; $display("FAIL ovf_rec%0d got=%h exp=%h", pops, {ev_type, ev_a, ev_b}, m_head()); end
      end
      step();
    end
    checks++; if (done !== 1'b1 || pops != 15) begin failures++; $display("FAIL ovf_drain got done=%b pops=%0d exp done=1 pops=15", done, pops); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      regWrite = 1'($urandom_range(0, 1)); writeReg = 3'($urandom); writeData = 16'($urandom);
      memRead = 0; memWrite = 0;
      case ($urandom_range(0, 2)) 1: memRead = 1; 2: memWrite = 1; default: ;
      endcase
      memAddr = 16'($urandom); memDataIn = 16'($urandom); memDataOut = 16'($urandom);
      iCacheReq = 1'($urandom); iCacheHit = 1'($urandom); dCacheReq = 1'($urandom); dCacheHit = 1'($urandom);
      ev_ready = ($urandom_range(0, 9) < 4);
      step();
      checks++; if ({ev_valid, ev_type, ev_a, ev_b} !== {mq.size() > 0, m_head()}) begin failures++; $display("FAIL rand_rec c=%0d got=%h exp=%h", c, {ev_valid, ev_type, ev_a, ev_b}, {mq.size() > 0, m_head()}); end
      checks++; if ({trace_afull, overflow, done} !== {(D - mq.size()) < 3, m_ovf, 1'b0}) begin failures++; $display("FAIL rand_flags c=%0d got=%b exp=%b", c, {trace_afull, overflow, done}, {(D - mq.size()) < 3, m_ovf, 1'b0}); end
      checks++; if ({cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt} !== m_cnts()) begin failures++; $display("FAIL rand_cnts c=%0d got=%h exp=%h", c, {cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt}, m_cnts()); end
    end
    idle();
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    bit hs, seen = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      case ($urandom_range(0, 2))
        0: begin regWrite = 1; writeReg = 3'($urandom); writeData = 16'($urandom); end
        1: begin memRead = 1; memAddr = 16'($urandom); memDataOut = 16'($urandom); end
        default: begin memWrite = 1; memAddr = 16'($urandom); memDataIn = 16'($urandom); end
      endcase
      dCacheReq = 1;
      step();
    end
    idle(); halt = 1;
    step(); idle();
    frozen = m_cyc;
    checks++; if (cycle_cnt !== 32'd6 || inst_cnt !== m_inst) begin failures++; $display("FAIL halt_cnt got cyc=%0d inst=%0d exp cyc=6 inst=%0d", cycle_cnt, inst_cnt, m_inst); end
    for (int i = 0; i < 60 && !seen; i++) begin
      ev_ready = 1'($urandom); regWrite = 1'($urandom); dCacheReq = 1'($urandom);
      hs = ev_valid && ev_ready && ev_type == 2'd3;
      checks++; if ({ev_valid, ev_type, ev_a, ev_b} !== {mq.size() > 0, m_head()}) begin failures++; $display("FAIL halt_rec i=%0d got=%h exp=%h", i, {ev_valid, ev_type, ev_a, ev_b}, {mq.size() > 0, m_head()}); end
      step();
      checks++; if ({done, ev_valid} !== {hs, hs ? 1'b0 : mq.size() > 0}) begin failures++; $display("FAIL halt_done i=%0d got=%b exp=%b", i, {done, ev_valid}, {hs, hs ? 1'b0 : mq.size() > 0}); end
      seen = hs;
    end
    idle();
    checks++; if (!seen || cycle_cnt !== frozen || {cycle_cnt, inst_cnt, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt} !== m_cnts()) begin failures++; $display("FAIL halt_end got seen=%b cyc=%0d exp seen=1 cyc=%0d", seen, cycle_cnt, frozen); end
  endtask

  task automatic test_mid_drain_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin regWrite = 1; writeReg = 3'(i); writeData = 16'(i); step(); end
    idle(); halt = 1; step(); idle();
    checks++; if ({ev_valid, done} !== 2'b10) begin failures++; $display("FAIL drain_pre got=%b exp=10", {ev_valid, done}); end
    rst = 1;
    #2;
    checks++; if ({ev_valid, done, cycle_cnt, inst_cnt} !== 66'h0) begin failures++; $display("FAIL drain_rst got valid=%b done=%b cyc=%0d inst=%0d exp all 0", ev_valid, done, cycle_cnt, inst_cnt); end
    @(posedge clk); #1 rst = 0;
    model_reset();
    for (int i = 0; i < 10; i++) begin dCacheHit = 1; dCacheReq = 1; step(); end
    idle();
    checks++; if ({dc_req_cnt, dc_hit_cnt, cycle_cnt} !== {m_dcr, m_dch, 32'd10}) begin failures++; $display("FAIL dcache_cnt got req=%0d hit=%0d cyc=%0d exp req=%0d hit=%0d cyc=10", dc_req_cnt, dc_hit_cnt, cycle_cnt, m_dcr, m_dch); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_reg();
    test_reg_store();
    test_load();
    test_overflow();
    test_random();
    test_halt();
    test_mid_drain_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
